// File: rtl/ddr2_cmd_pkg.sv
// rtl/ddr2_cmd_pkg.sv - DDR2 command types, step record and shared constants
//
// Purpose: command enum and its {cs_n, ras_n, cas_n, we_n} encoding, the
// init step record consumed by the sequencer, and small parameter helpers.
// Ports: none (package).

`ifndef DRAM_BA_WIDTH
`define DRAM_BA_WIDTH 2
`endif
`ifndef DRAM_ADDR_WIDTH
`define DRAM_ADDR_WIDTH 13
`endif

package ddr2_cmd_pkg;

  localparam int BA_W        = `DRAM_BA_WIDTH;
  localparam int ADDR_W      = `DRAM_ADDR_WIDTH;
  localparam int STEP_WAIT_W = 16;
  localparam int NUM_STEPS   = 11;

  localparam logic [ADDR_W-1:0] A10_PRE       = ADDR_W'(13'h400);
  localparam logic [ADDR_W-1:0] EMR1_OCD_MASK = ADDR_W'(13'h380);
  localparam logic [ADDR_W-1:0] MR_DLL_RESET  = ADDR_W'(13'h100);

  typedef enum logic [2:0] {
    CMD_DESELECT,
    CMD_NOP,
    CMD_PRE_ALL,
    CMD_MRS,
    CMD_REF
  } ddr2_cmd_e;

  typedef struct packed {
    ddr2_cmd_e               cmd;
    logic [BA_W-1:0]         ba;
    logic [ADDR_W-1:0]       addr;
    logic [STEP_WAIT_W-1:0]  wait_cyc;
  } ddr2_step_t;

  // Returns {cs_n, ras_n, cas_n, we_n}.
  function automatic logic [3:0] ddr2_cmd_encode(input ddr2_cmd_e cmd);
    case (cmd)
      CMD_NOP:     return 4'b0111;
      CMD_PRE_ALL: return 4'b0010;
      CMD_MRS:     return 4'b0000;
      CMD_REF:     return 4'b0001;
      default:     return 4'b1111;
    endcase
  endfunction

  // Zero-length waits would collapse two commands into one cycle.
  function automatic int unsigned clamp1(input int unsigned v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ddr2_init_step_rom.sv
// rtl/ddr2_init_step_rom.sv - combinational table of the DDR2 init command steps
//
// Purpose: maps a step index to the command, bank, address and the wait that
// follows it. Indices past the last step return a NOP record.
// Ports:
//   step_idx_i  in   4        step index 0..10
//   step_o      out  struct   command / ba / addr / following wait

module ddr2_init_step_rom
  import ddr2_cmd_pkg::*;
#(
  parameter logic [ADDR_W-1:0] MR_VALUE   = 13'h0A52,
  parameter logic [ADDR_W-1:0] EMR1_VALUE = 13'h0000,
  parameter logic [ADDR_W-1:0] EMR2_VALUE = 13'h0000,
  parameter logic [ADDR_W-1:0] EMR3_VALUE = 13'h0000,
  parameter int unsigned       T_RP       = 3,
  parameter int unsigned       T_MRD      = 2,
  parameter int unsigned       T_RFC      = 26
) (
  input  logic [3:0] step_idx_i,
  output ddr2_step_t step_o
);

  localparam logic [STEP_WAIT_W-1:0] W_RP  = STEP_WAIT_W'(clamp1(T_RP));
  localparam logic [STEP_WAIT_W-1:0] W_MRD = STEP_WAIT_W'(clamp1(T_MRD));
  localparam logic [STEP_WAIT_W-1:0] W_RFC = STEP_WAIT_W'(clamp1(T_RFC));
  localparam logic [STEP_WAIT_W-1:0] W_ONE = STEP_WAIT_W'(1);

  // EMR1 bits [9:7] select OCD mode: 000 normal/exit, 111 OCD default.
  localparam logic [ADDR_W-1:0] EMR1_NORM = EMR1_VALUE & ~EMR1_OCD_MASK;
  localparam logic [ADDR_W-1:0] EMR1_OCD  = EMR1_VALUE | EMR1_OCD_MASK;

  always_comb begin
    step_o = '{cmd: CMD_NOP, ba: '0, addr: '0, wait_cyc: W_ONE};
    case (step_idx_i)
      4'd0:  step_o = '{cmd: CMD_PRE_ALL, ba: BA_W'(0), addr: A10_PRE,                 wait_cyc: W_RP};
      4'd1:  step_o = '{cmd: CMD_MRS,     ba: BA_W'(2), addr: EMR2_VALUE,              wait_cyc: W_MRD};
      4'd2:  step_o = '{cmd: CMD_MRS,     ba: BA_W'(3), addr: EMR3_VALUE,              wait_cyc: W_MRD};
      4'd3:  step_o = '{cmd: CMD_MRS,     ba: BA_W'(1), addr: EMR1_NORM,               wait_cyc: W_MRD};
      4'd4:  step_o = '{cmd: CMD_MRS,     ba: BA_W'(0), addr: MR_VALUE | MR_DLL_RESET, wait_cyc: W_MRD};
      4'd5:  step_o = '{cmd: CMD_PRE_ALL, ba: BA_W'(0), addr: A10_PRE,                 wait_cyc: W_RP};
      4'd6:  step_o = '{cmd: CMD_REF,     ba: BA_W'(0), addr: '0,                      wait_cyc: W_RFC};
      4'd7:  step_o = '{cmd: CMD_REF,     ba: BA_W'(0), addr: '0,                      wait_cyc: W_RFC};
      4'd8:  step_o = '{cmd: CMD_MRS,     ba: BA_W'(0), addr: MR_VALUE,                wait_cyc: W_MRD};
      4'd9:  step_o = '{cmd: CMD_MRS,     ba: BA_W'(1), addr: EMR1_OCD,                wait_cyc: W_MRD};
      4'd10: step_o = '{cmd: CMD_MRS,     ba: BA_W'(1), addr: EMR1_NORM,               wait_cyc: W_MRD};
      default: ;
    endcase
  end

endmodule

// File: rtl/ddr2_init_seq.sv
// rtl/ddr2_init_seq.sv - DDR2 DIMM power-up initialization sequencer
//
// Purpose: after reset holds CKE low, issues NOPs, then walks the init step
// table (precharge, mode-register loads, refreshes, OCD default/exit) and
// raises init_done once the last step and the DLL lock time are satisfied.
// Ports:
//   clk        in   1   controller clock (DIMM ck)
//   rst        in   1   synchronous active-high reset
//   cke        out  1   clock enable
//   cs_n/ras_n/cas_n/we_n  out 1 each  command strobes
//   ba         out  DRAM_BA_WIDTH    bank / mode-register select
//   addr       out  DRAM_ADDR_WIDTH  address / mode-register value
//   odt        out  1   on-die termination, always 0
//   init_done  out  1   sequence complete, sticky until rst

module ddr2_init_seq
  import ddr2_cmd_pkg::*;
#(
  parameter logic [ADDR_W-1:0] MR_VALUE   = 13'h0A52,
  parameter logic [ADDR_W-1:0] EMR1_VALUE = 13'h0000,
  parameter logic [ADDR_W-1:0] EMR2_VALUE = 13'h0000,
  parameter logic [ADDR_W-1:0] EMR3_VALUE = 13'h0000,
  parameter int unsigned       T_INIT     = 40000,
  parameter int unsigned       T_NOP      = 80,
  parameter int unsigned       T_RP       = 3,
  parameter int unsigned       T_MRD      = 2,
  parameter int unsigned       T_RFC      = 26,
  parameter int unsigned       T_DLL      = 200
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        cke,
  output logic                        cs_n,
  output logic                        ras_n,
  output logic                        cas_n,
  output logic                        we_n,
  output logic [`DRAM_BA_WIDTH-1:0]   ba,
  output logic [`DRAM_ADDR_WIDTH-1:0] addr,
  output logic                        odt,
  output logic                        init_done
);

  localparam int unsigned T_INIT_C = clamp1(T_INIT);
  localparam int unsigned T_NOP_C  = clamp1(T_NOP);
  localparam int unsigned T_DLL_C  = clamp1(T_DLL);
  localparam int unsigned CNT_MAX  = max2(max2(T_INIT_C, T_NOP_C),
                                          max2(clamp1(T_RFC), max2(clamp1(T_RP), clamp1(T_MRD))));
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int DLL_W = $clog2(T_DLL_C + 1);

  typedef enum logic [2:0] {
    ST_RESET_WAIT,
    ST_NOP_WAIT,
    ST_RUN,
    ST_DLL_WAIT,
    ST_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [3:0]              step_q, step_d;
  logic [STEP_WAIT_W-1:0]  wait_q, wait_d;
  logic [DLL_W-1:0]        dll_q, dll_d;
  logic                    cke_q, cke_d;
  logic [3:0]              strb_q, strb_d;
  logic [BA_W-1:0]         ba_q, ba_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic                    done_q, done_d;

  ddr2_cmd_e               cmd_d;
  ddr2_step_t              step;
  logic                    issue;
  logic                    dll_done;

  ddr2_init_step_rom #(
    .MR_VALUE   (MR_VALUE),
    .EMR1_VALUE (EMR1_VALUE),
    .EMR2_VALUE (EMR2_VALUE),
    .EMR3_VALUE (EMR3_VALUE),
    .T_RP       (T_RP),
    .T_MRD      (T_MRD),
    .T_RFC      (T_RFC)
  ) u_rom (
    .step_idx_i (step_q),
    .step_o     (step)
  );

  assign dll_done = 32'(dll_q) >= T_DLL_C;

  // cnt_q counts the cycles already shown in the current phase; a phase
  // ends on the edge where it reaches that phase's length. Outputs are
  // computed for the state being entered and registered on the same edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    wait_d  = wait_q;
    dll_d   = dll_q;
    cke_d   = 1'b1;
    cmd_d   = CMD_NOP;
    ba_d    = '0;
    addr_d  = '0;
    done_d  = 1'b0;
    issue   = 1'b0;

    // Once started by the DLL-reset MRS the DLL counter free-runs to saturation.
    if (dll_q != '0 && 32'(dll_q) < T_DLL_C) dll_d = dll_q + 1'b1;

    case (state_q)
      ST_RESET_WAIT: begin
        if (32'(cnt_q) >= T_INIT_C) begin
          state_d = ST_NOP_WAIT;
          cnt_d   = CNT_W'(1);
        end else begin
          cke_d = 1'b0;
          cmd_d = CMD_DESELECT;
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_NOP_WAIT: begin
        if (32'(cnt_q) >= T_NOP_C) issue = 1'b1;
        else                       cnt_d = cnt_q + 1'b1;
      end
      ST_RUN: begin
        if (32'(cnt_q) >= 32'(wait_q)) begin
          if (step_q == 4'(NUM_STEPS)) begin
            if (dll_done) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_DLL_WAIT;
            end
          end else begin
            issue = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DLL_WAIT: begin
        if (dll_done) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: done_d = 1'b1;
      default: state_d = ST_RESET_WAIT;
    endcase

    if (issue) begin
      state_d = ST_RUN;
      cmd_d   = step.cmd;
      ba_d    = step.ba;
      addr_d  = step.addr;
      wait_d  = step.wait_cyc;
      step_d  = step_q + 4'd1;
      cnt_d   = CNT_W'(1);
      if (step_q == 4'd4) dll_d = DLL_W'(1);
    end

    strb_d = ddr2_cmd_encode(cmd_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RESET_WAIT;
      cnt_q   <= '0;
      step_q  <= '0;
      wait_q  <= '0;
      dll_q   <= '0;
      cke_q   <= 1'b0;
      strb_q  <= 4'b1111;
      ba_q    <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      wait_q  <= wait_d;
      dll_q   <= dll_d;
      cke_q   <= cke_d;
      strb_q  <= strb_d;
      ba_q    <= ba_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
    end
  end

  assign cke                        = cke_q;
  assign {cs_n, ras_n, cas_n, we_n} = strb_q;
  assign ba                         = ba_q;
  assign addr                       = addr_q;
  assign odt                        = 1'b0;
  assign init_done                  = done_q;

endmodule

// File: tb/tb_ddr2_init_seq.sv
// tb/tb_ddr2_init_seq.sv - directed schedule checks for ddr2_init_seq

module tb_ddr2_init_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst;
  logic [2:0]       cke_v, cs_v, ras_v, cas_v, we_v, odt_v, done_v;
  logic [2:0][1:0]  ba_v;
  logic [2:0][12:0] addr_v;

  // d0: base timing, d1: T_DLL=40, d2: all timing parameters 0
  ddr2_init_seq #(.T_INIT(10), .T_NOP(4), .T_RP(3), .T_MRD(2), .T_RFC(8), .T_DLL(20)) u_d0 (
    .clk(clk), .rst(rst[0]), .cke(cke_v[0]), .cs_n(cs_v[0]), .ras_n(ras_v[0]),
    .cas_n(cas_v[0]), .we_n(we_v[0]), .ba(ba_v[0]), .addr(addr_v[0]),
    .odt(odt_v[0]), .init_done(done_v[0]));

  ddr2_init_seq #(.T_INIT(10), .T_NOP(4), .T_RP(3), .T_MRD(2), .T_RFC(8), .T_DLL(40)) u_d1 (
    .clk(clk), .rst(rst[1]), .cke(cke_v[1]), .cs_n(cs_v[1]), .ras_n(ras_v[1]),
    .cas_n(cas_v[1]), .we_n(we_v[1]), .ba(ba_v[1]), .addr(addr_v[1]),
    .odt(odt_v[1]), .init_done(done_v[1]));

  ddr2_init_seq #(.T_INIT(0), .T_NOP(0), .T_RP(0), .T_MRD(0), .T_RFC(0), .T_DLL(0)) u_d2 (
    .clk(clk), .rst(rst[2]), .cke(cke_v[2]), .cs_n(cs_v[2]), .ras_n(ras_v[2]),
    .cas_n(cas_v[2]), .we_n(we_v[2]), .ba(ba_v[2]), .addr(addr_v[2]),
    .odt(odt_v[2]), .init_done(done_v[2]));

  // Hand-computed schedule: {cke, cs_n, ras_n, cas_n, we_n, ba, addr, odt, init_done}
  int         base_steps [11] = '{14, 17, 19, 21, 23, 25, 28, 36, 44, 46, 48};
  logic [3:0] step_cmd   [11] = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010,
                                  4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
  logic [1:0] step_ba    [11] = '{2'd0, 2'd2, 2'd3, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
  logic [12:0] step_addr [11] = '{13'h400, 13'h000, 13'h000, 13'h000, 13'hB52, 13'h400,
                                  13'h000, 13'h000, 13'hA52, 13'h380, 13'h000};
  int         done_cyc   [3]  = '{50, 63, 13};
  int         tinit      [3]  = '{10, 10, 1};

  localparam logic [21:0] RST_VEC = {1'b0, 4'b1111, 2'd0, 13'd0, 1'b0, 1'b0};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [21:0] obs(input int s);
    return {cke_v[s], cs_v[s], ras_v[s], cas_v[s], we_v[s], ba_v[s], addr_v[s], odt_v[s], done_v[s]};
  endfunction

  function automatic logic [21:0] expv(input int s, input int c);
    logic [3:0]  cmd;
    logic [1:0]  b;
    logic [12:0] a;
    int          at;
    cmd = 4'b1111;
    b   = 2'd0;
    a   = 13'd0;
    if (c >= tinit[s]) begin
      cmd = 4'b0111;
      for (int k = 0; k < 11; k++) begin
        at = (s == 2) ? (2 + k) : base_steps[k];
        if (c == at) begin
          cmd = step_cmd[k];
          b   = step_ba[k];
          a   = step_addr[k];
        end
      end
    end
    return {c >= tinit[s], cmd, b, a, 1'b0, c >= done_cyc[s]};
  endfunction

  // Called at a negedge; the next posedge is cycle 0 after release.
  task automatic run_sched(input int s, input int ncyc);
    rst[s] = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("d%0d_cyc%0d", s, c), 32'(obs(s)), 32'(expv(s, c)));
    end
  endtask

  initial begin
    rst = 3'b111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) check($sformatf("reset_d%0d", s), 32'(obs(s)), 32'(RST_VEC));

    // full base schedule plus 100 cycles of hold after init_done
    run_sched(0, 151);

    // restart, then hit rst at cycle 30 for two cycles mid-sequence
    rst[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rerst_d0", 32'(obs(0)), 32'(RST_VEC));
    run_sched(0, 30);
    rst[0] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("midrst_d0_%0d", i), 32'(obs(0)), 32'(RST_VEC));
    end
    run_sched(0, 60);

    // DLL time dominates: init_done at 63
    run_sched(1, 70);

    // all timing parameters clamped to 1
    run_sched(2, 20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
